// File: rtl/text_pixel_gen.sv
// text_pixel_gen: 80x30 text-mode pixel generator with a valid/ready character port
module text_pixel_gen #(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        char_valid,
  input  logic [6:0]  char_code,
  output logic        char_ready,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb,
  output logic        pixel_on,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);
  typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;
  localparam logic [11:0] LAST_CELL = 12'd2399;
  state_t      state_q, state_d;
  logic [11:0] clr_idx_q, clr_idx_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  char_q, char_d;
  logic [2:0]  x_d1_q, x_d1_d;
  logic [3:0]  y_d1_q, y_d1_d;
  logic        von_d1_q, von_d1_d;
  logic [11:0] rgb_q, rgb_d;
  logic        pixel_on_q, pixel_on_d;
  logic [6:0]  mem [0:2399];
  logic        mem_we;
  logic [11:0] wr_addr, rd_addr, cur_addr, bs_addr;
  logic [6:0]  wr_data, bs_col;
  logic [4:0]  bs_row, row_inc;
  logic        clearing, accept, is_nl, is_bs, is_ff, home;
  assign clearing = state_q == CLEAR;
  assign accept   = char_valid & ~clearing;
  assign is_nl    = char_code == 7'h0A;
  assign is_bs    = char_code == 7'h08;
  assign is_ff    = char_code == 7'h0C;
  assign home     = (col_q == 7'd0) && (row_q == 5'd0);
  assign row_inc  = (row_q == 5'd29) ? 5'd0 : row_q + 5'd1;
  assign bs_col   = (col_q == 7'd0) ? 7'd79 : col_q - 7'd1;
  assign bs_row   = (col_q == 7'd0) ? row_q - 5'd1 : row_q;
  assign cur_addr = 12'(row_q) * 12'd80 + 12'(col_q);
  assign bs_addr  = 12'(bs_row) * 12'd80 + 12'(bs_col);
  // State, cursor and pixel pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      char_q     <= '0;
      x_d1_q     <= '0;
      y_d1_q     <= '0;
      von_d1_q   <= 1'b0;
      rgb_q      <= '0;
      pixel_on_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      char_q     <= char_d;
      x_d1_q     <= x_d1_d;
      y_d1_q     <= y_d1_d;
      von_d1_q   <= von_d1_d;
      rgb_q      <= rgb_d;
      pixel_on_q <= pixel_on_d;
    end
  end
  // Character buffer write port; contents are only initialised by CLEAR
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end
  // Next state: sweep the buffer in CLEAR, interpret accepted codes in IDLE
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    col_d     = col_q;
    row_d     = row_q;
    if (clearing) begin
      clr_idx_d = (clr_idx_q == LAST_CELL) ? 12'd0 : clr_idx_q + 12'd1;
      if (clr_idx_q == LAST_CELL) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    end else if (accept) begin
      if (is_nl) begin
        col_d = '0;
        row_d = row_inc;
      end else if (is_bs) begin
        col_d = home ? col_q : bs_col;
        row_d = home ? row_q : bs_row;
      end else if (is_ff) begin
        state_d   = CLEAR;
        clr_idx_d = '0;
      end else begin
        col_d = (col_q == 7'd79) ? 7'd0 : col_q + 7'd1;
        row_d = (col_q == 7'd79) ? row_inc : row_q;
      end
    end
  end
  // FSM outputs: handshake and buffer write request
  always_comb begin
    char_ready = ~clearing;
    mem_we     = clearing | (accept & ~is_nl & ~is_ff & ~(is_bs & home));
    wr_addr    = clearing ? clr_idx_q : is_bs ? bs_addr : cur_addr;
    wr_data    = (clearing | is_bs) ? 7'h20 : char_code;
  end
  // Pixel pipeline: cell lookup, then glyph bit select into a registered colour
  always_comb begin
    rd_addr    = 12'(pixel_y[8:4]) * 12'd80 + 12'(pixel_x[9:3]);
    char_d     = mem[rd_addr];
    x_d1_d     = pixel_x[2:0];
    y_d1_d     = pixel_y[3:0];
    von_d1_d   = video_on;
    pixel_on_d = von_d1_q;
    rgb_d      = !von_d1_q ? 12'h000 : clearing ? BG_COLOR :
                 rom_data[3'd7 - x_d1_q] ? FG_COLOR : BG_COLOR;
  end
  assign rom_addr   = {char_q, y_d1_q};
  assign rgb        = rgb_q;
  assign pixel_on   = pixel_on_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
endmodule
